// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator. It divides the system clock
//            down to a pixel tick and runs the horizontal and vertical counters
//            on that tick. A registered decode stage, one clk behind the
//            counters, produces the syncs, the active-video flag and the gated
//            colour. It also emits one-clk line-start and frame-start strobes.
//
// Ports    : clk          in   system clock
//            reset        in   synchronous reset, active-low (0 = reset)
//            swcolors     in   switch colour input [COLOR_W]
//            test_mode    in   colour-bar select (VGA_TEST_PATTERN_EN only)
//            h_sync       out  horizontal sync, asserted level HS_POL
//            v_sync       out  vertical sync, asserted level VS_POL
//            video_on_out out  high inside the visible region
//            pixel_x      out  horizontal counter [X_W]
//            pixel_y      out  vertical counter [Y_W]
//            colors_out   out  colour to DAC [COLOR_W]
//            clk_out      out  pixel tick, one clk wide every CLK_DIV clks
//            line_start   out  one-clk strobe when pixel_x wraps to 0
//            frame_start  out  one-clk strobe when (pixel_x,pixel_y) wrap
//
// Options  : VGA_TEST_PATTERN_EN - when defined, adds the test_mode input.
//            With test_mode=1 in the visible region, colors_out shows
//            64-pixel-wide vertical colour bars taken from pixel_x.
//
// Revision : 1.0 - initial parametrised release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] swcolors,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    output logic               h_sync,
    output logic               v_sync,
    output logic               video_on_out,
    output logic [X_W-1:0]     pixel_x,
    output logic [Y_W-1:0]     pixel_y,
    output logic [COLOR_W-1:0] colors_out,
    output logic               clk_out,
    output logic               line_start,
    output logic               frame_start
);

    // ------------------------------------------------------------------------
    // Derived constants. All decode thresholds are pre-sized to the counter
    // widths so every comparison below is unsigned at X_W / Y_W.
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   c_X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   c_Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   c_H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   c_V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   c_HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   c_HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   c_VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   c_VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_clk_out;
    logic             w_tick;

    // The tick fires on the last divider count. With CLK_DIV==1 the counter is
    // stuck at 0 == c_DIV_LAST, so the tick is permanently high.
    assign w_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_clk_out <= 1'b0;
        end else begin
            r_clk_out <= w_tick;
            if (w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raster counters and line / frame strobes
    // ------------------------------------------------------------------------
    logic [X_W-1:0] r_pixel_x;
    logic [Y_W-1:0] r_pixel_y;
    logic           r_line_start;
    logic           r_frame_start;
    logic           w_x_last;
    logic           w_y_last;

    assign w_x_last = (r_pixel_x == c_X_LAST);
    assign w_y_last = (r_pixel_y == c_Y_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes are loaded on the same edge that performs the wrap, so
            // they are high during the first clk in which the counter reads 0.
            r_line_start  <= w_tick && w_x_last;
            r_frame_start <= w_tick && w_x_last && w_y_last;
            if (w_tick) begin
                if (w_x_last) begin
                    r_pixel_x <= '0;
                    if (w_y_last) begin
                        r_pixel_y <= '0;
                    end else begin
                        r_pixel_y <= r_pixel_y + Y_W'(1);
                    end
                end else begin
                    r_pixel_x <= r_pixel_x + X_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decode stage: registered, one clk behind the counters
    // ------------------------------------------------------------------------
    logic               w_hs_active;
    logic               w_vs_active;
    logic               w_video_on;
    logic [COLOR_W-1:0] w_color;
    logic               r_h_sync;
    logic               r_v_sync;
    logic               r_video_on;
    logic [COLOR_W-1:0] r_colors;

    assign w_hs_active = (r_pixel_x >= c_HS_START) && (r_pixel_x < c_HS_END);
    assign w_vs_active = (r_pixel_y >= c_VS_START) && (r_pixel_y < c_VS_END);
    assign w_video_on  = (r_pixel_x < c_H_ACT) && (r_pixel_y < c_V_ACT);

    always_comb begin
        w_color = '0;
        if (w_video_on) begin
            w_color = swcolors;
`ifdef VGA_TEST_PATTERN_EN
            // Bars change every 64 pixels: take the pixel_x bits above bit 5.
            if (test_mode) begin
                w_color = r_pixel_x[6+COLOR_W-1:6];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h_sync   <= ~HS_POL;
            r_v_sync   <= ~VS_POL;
            r_video_on <= 1'b0;
            r_colors   <= '0;
        end else begin
            r_h_sync   <= w_hs_active ? HS_POL : ~HS_POL;
            r_v_sync   <= w_vs_active ? VS_POL : ~VS_POL;
            r_video_on <= w_video_on;
            r_colors   <= w_color;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign h_sync       = r_h_sync;
    assign v_sync       = r_v_sync;
    assign video_on_out = r_video_on;
    assign pixel_x      = r_pixel_x;
    assign pixel_y      = r_pixel_y;
    assign colors_out   = r_colors;
    assign clk_out      = r_clk_out;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench for vga_timing_gen. Three instances
//            share one clock: default 640x480 timing, a tiny raster for frame
//            level checks, and a high-true-sync CLK_DIV=4 raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- default instance ----------------
    logic       rst_def = 1'b0;
    logic [2:0] sw_def  = 3'b101;
    logic       tm_def  = 1'b0;
    logic       d_hs, d_vs, d_vid, d_clko, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [2:0] d_col;

    vga_timing_gen u_dut_def (
        .clk(clk), .reset(rst_def), .swcolors(sw_def),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_def),
`endif
        .h_sync(d_hs), .v_sync(d_vs), .video_on_out(d_vid),
        .pixel_x(d_x), .pixel_y(d_y), .colors_out(d_col),
        .clk_out(d_clko), .line_start(d_ls), .frame_start(d_fs)
    );

    // ---------------- small instance: H 8/2/2/2, V 4/1/1/1, CLK_DIV 1 ----
    logic       rst_small = 1'b0;
    logic [2:0] sw_small  = 3'b011;
    logic       tm_small  = 1'b0;
    logic       s_hs, s_vs, s_vid, s_clko, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [2:0] s_col;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
    ) u_dut_small (
        .clk(clk), .reset(rst_small), .swcolors(sw_small),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_small),
`endif
        .h_sync(s_hs), .v_sync(s_vs), .video_on_out(s_vid),
        .pixel_x(s_x), .pixel_y(s_y), .colors_out(s_col),
        .clk_out(s_clko), .line_start(s_ls), .frame_start(s_fs)
    );

    // ---------------- polarity instance: H 160/8/16/8, V 4/1/1/1 ----------
    logic       rst_pol = 1'b0;
    logic [2:0] sw_pol  = 3'b110;
    logic       tm_pol  = 1'b1;
    logic       p_hs, p_vs, p_vid, p_clko, p_ls, p_fs;
    logic [9:0] p_x, p_y;
    logic [2:0] p_col;

    vga_timing_gen #(
        .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(4)
    ) u_dut_pol (
        .clk(clk), .reset(rst_pol), .swcolors(sw_pol),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_pol),
`endif
        .h_sync(p_hs), .v_sync(p_vs), .video_on_out(p_vid),
        .pixel_x(p_x), .pixel_y(p_y), .colors_out(p_col),
        .clk_out(p_clko), .line_start(p_ls), .frame_start(p_fs)
    );

    // Advance one clk and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_def = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (d_x !== 10'd0) begin errors++; $display("FAIL reset_pixel_x: got %0d expected 0", d_x); end
        checks++; if (d_y !== 10'd0) begin errors++; $display("FAIL reset_pixel_y: got %0d expected 0", d_y); end
        checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL reset_h_sync: got %b expected 1", d_hs); end
        checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL reset_v_sync: got %b expected 1", d_vs); end
        checks++; if (d_vid !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %b expected 0", d_vid); end
        checks++; if (d_col !== 3'b000) begin errors++; $display("FAIL reset_colors: got %b expected 000", d_col); end
        checks++; if (d_clko !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b expected 0", d_clko); end
        checks++; if ({d_ls, d_fs} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {d_ls, d_fs}); end
        rst_def = 1'b1;
        // CLK_DIV=2: clk_out low on edge 1, high on edge 2, then alternating.
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (d_clko !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL release_clk_out edge %0d: got %b expected %b", i, d_clko, ((i % 2) == 0));
            end
        end
        checks++; if (d_x !== 10'd2) begin errors++; $display("FAIL release_pixel_x: got %0d expected 2", d_x); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_htiming();
        int  n_x656 = -1, n_fall1 = -1, n_fall2 = -1, n_rise = -1;
        int  n_ls1 = -1, n_ls2 = -1;
        int  x_at_ls = -1, y_at_ls = -1;
        logic prev_hs;
        prev_hs = d_hs;
        for (int n = 0; n < 4000; n++) begin
            step();
            if (d_x == 10'd656 && n_x656 < 0) n_x656 = n;
            if (prev_hs && !d_hs) begin
                if (n_fall1 < 0) n_fall1 = n;
                else if (n_fall2 < 0) n_fall2 = n;
            end
            if (!prev_hs && d_hs && n_fall1 >= 0 && n_rise < 0) n_rise = n;
            if (d_ls) begin
                if (n_ls1 < 0) begin
                    n_ls1 = n; x_at_ls = int'(d_x); y_at_ls = int'(d_y);
                end else if (n_ls2 < 0) begin
                    n_ls2 = n;
                end
            end
            prev_hs = d_hs;
            if (n_fall2 >= 0 && n_ls2 >= 0) break;
        end
        checks++; if (n_fall1 - n_x656 != 1) begin errors++; $display("FAIL hsync_start_delay: got %0d expected 1", n_fall1 - n_x656); end
        checks++; if (n_rise - n_fall1 != 192) begin errors++; $display("FAIL hsync_width: got %0d expected 192", n_rise - n_fall1); end
        checks++; if (n_fall2 - n_fall1 != 1600) begin errors++; $display("FAIL line_period: got %0d expected 1600", n_fall2 - n_fall1); end
        checks++; if (n_ls2 - n_ls1 != 1600) begin errors++; $display("FAIL line_start_period: got %0d expected 1600", n_ls2 - n_ls1); end
        checks++; if (x_at_ls != 0) begin errors++; $display("FAIL line_start_x: got %0d expected 0", x_at_ls); end
        checks++; if (y_at_ls != 1) begin errors++; $display("FAIL line_start_y: got %0d expected 1", y_at_ls); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_colour();
        int bad = 0, vid_cnt = 0, found = 0;
        for (int n = 0; n < 1600; n++) begin
            step();
            if (d_vid) vid_cnt++;
            if (d_col !== (d_vid ? 3'b101 : 3'b000)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL colour_gating: got %0d bad samples expected 0", bad); end
        checks++; if (vid_cnt != 1280) begin errors++; $display("FAIL video_on_per_line: got %0d expected 1280", vid_cnt); end
        for (int n = 0; n < 2000; n++) begin
            step();
            if (d_x == 10'd100) begin found = 1; break; end
        end
        checks++; if (!(found == 1 && d_col === 3'b101)) begin errors++; $display("FAIL colour_before_change: got %b expected 101", d_col); end
        sw_def = 3'b010;
        step();
        checks++; if (d_col !== 3'b010) begin errors++; $display("FAIL colour_after_change: got %b expected 010", d_col); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_frame();
        int n_fs1 = -1, n_fs2 = -1, vid_cnt = 0, vs_cnt = 0, vs_bad = 0;
        int ls_cnt = 0;
        logic ls_at_fs = 1'b0;
        logic [9:0] prev_y;
        rst_small = 1'b0;
        repeat (2) step();
        rst_small = 1'b1;
        prev_y = s_y;
        for (int n = 1; n <= 400; n++) begin
            step();
            if (s_fs) begin
                if (n_fs1 < 0) begin n_fs1 = n; ls_at_fs = s_ls; end
                else if (n_fs2 < 0) n_fs2 = n;
            end
            if (n_fs1 >= 0 && n_fs2 < 0) begin
                if (s_vid) vid_cnt++;
                if (s_ls) ls_cnt++;
                if (!s_vs) begin
                    vs_cnt++;
                    if (prev_y != 10'd5) vs_bad++;
                end
            end
            prev_y = s_y;
            if (n_fs2 >= 0) break;
        end
        checks++; if (n_fs1 != 98) begin errors++; $display("FAIL first_frame_start: got %0d expected 98", n_fs1); end
        checks++; if (n_fs2 - n_fs1 != 98) begin errors++; $display("FAIL frame_period: got %0d expected 98", n_fs2 - n_fs1); end
        checks++; if (ls_at_fs !== 1'b1) begin errors++; $display("FAIL frame_implies_line: got %b expected 1", ls_at_fs); end
        checks++; if (ls_cnt != 7) begin errors++; $display("FAIL lines_per_frame: got %0d expected 7", ls_cnt); end
        checks++; if (vid_cnt != 32) begin errors++; $display("FAIL video_on_per_frame: got %0d expected 32", vid_cnt); end
        checks++; if (vs_cnt != 14) begin errors++; $display("FAIL vsync_width: got %0d expected 14", vs_cnt); end
        checks++; if (vs_bad != 0) begin errors++; $display("FAIL vsync_line: got %0d off-line samples expected 0", vs_bad); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_midframe_reset();
        int found = 0, n_fs = -1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (s_x == 10'd5 && s_y == 10'd2) begin found = 1; break; end
        end
        checks++; if (found != 1) begin errors++; $display("FAIL midframe_reach: got %0d expected 1", found); end
        rst_small = 1'b0;
        step();
        checks++; if ({s_x, s_y} !== 20'd0) begin errors++; $display("FAIL midframe_counters: got x=%0d y=%0d expected 0 0", s_x, s_y); end
        checks++; if ({s_hs, s_vs} !== 2'b11) begin errors++; $display("FAIL midframe_syncs: got %b expected 11", {s_hs, s_vs}); end
        checks++; if ({s_clko, s_ls, s_fs} !== 3'b000) begin errors++; $display("FAIL midframe_strobes: got %b expected 000", {s_clko, s_ls, s_fs}); end
        rst_small = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (s_fs) begin n_fs = n; break; end
        end
        checks++; if (n_fs != 98) begin errors++; $display("FAIL midframe_first_frame: got %0d expected 98", n_fs); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_polarity();
        int n_hi1 = -1, n_hi2 = -1, hi_cnt = 0;
        int hs_run = 0, hs_x = -1, vs_run = 0, bad_col = 0, bad_vid = 0;
        int hs_state = 0, vs_state = 0;
        logic [9:0] prev_x, prev_y;
        logic [2:0] exp_col, col80, exp80;
        logic       exp_vid, got80;
        got80 = 1'b0;
        col80 = 3'b000;
        checks++; if ({p_hs, p_vs} !== 2'b00) begin errors++; $display("FAIL pol_reset_syncs: got %b expected 00", {p_hs, p_vs}); end
        rst_pol = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (p_clko) begin
                hi_cnt++;
                if (n_hi1 < 0) n_hi1 = n; else if (n_hi2 < 0) n_hi2 = n;
            end
        end
        checks++; if (n_hi1 != 4) begin errors++; $display("FAIL div4_first_tick: got %0d expected 4", n_hi1); end
        checks++; if (n_hi2 - n_hi1 != 4) begin errors++; $display("FAIL div4_period: got %0d expected 4", n_hi2 - n_hi1); end
        checks++; if (hi_cnt != 2) begin errors++; $display("FAIL div4_width: got %0d expected 2", hi_cnt); end
        prev_x = p_x;
        prev_y = p_y;
        for (int n = 0; n < 8000; n++) begin
            step();
            // h_sync high-true pulse: measure the first complete pulse
            if (hs_state == 0 && p_hs) begin hs_state = 1; hs_x = int'(prev_x); end
            if (hs_state == 1) begin
                if (p_hs) hs_run++; else hs_state = 2;
            end
            if (vs_state == 0 && p_vs) vs_state = 1;
            if (vs_state == 1) begin
                if (p_vs) vs_run++; else vs_state = 2;
            end
            exp_vid = (prev_x < 10'd160) && (prev_y < 10'd4);
`ifdef VGA_TEST_PATTERN_EN
            exp_col = exp_vid ? prev_x[8:6] : 3'b000;
`else
            exp_col = exp_vid ? sw_pol : 3'b000;
`endif
            if (p_vid !== exp_vid) bad_vid++;
            if (p_col !== exp_col) bad_col++;
            if (!got80 && prev_x == 10'd80 && prev_y < 10'd4) begin got80 = 1'b1; col80 = p_col; end
            prev_x = p_x;
            prev_y = p_y;
            if (vs_state == 2 && hs_state == 2) break;
        end
`ifdef VGA_TEST_PATTERN_EN
        exp80 = 3'b001;
`else
        exp80 = 3'b110;
`endif
        checks++; if (hs_x != 168) begin errors++; $display("FAIL pol_hsync_start_x: got %0d expected 168", hs_x); end
        checks++; if (hs_run != 64) begin errors++; $display("FAIL pol_hsync_width: got %0d expected 64", hs_run); end
        checks++; if (vs_run != 768) begin errors++; $display("FAIL pol_vsync_width: got %0d expected 768", vs_run); end
        checks++; if (bad_vid != 0) begin errors++; $display("FAIL pol_video_on: got %0d bad samples expected 0", bad_vid); end
        checks++; if (bad_col != 0) begin errors++; $display("FAIL pol_colour: got %0d bad samples expected 0", bad_col); end
        checks++; if (!(got80 && col80 === exp80)) begin errors++; $display("FAIL pol_colour_x80: got %b expected %b", col80, exp80); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_htiming();
        test_colour();
        test_frame();
        test_midframe_reset();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal and vertical sync, active-video flag and pixel coordinates for any resolution and porch set.
- Generates its own pixel-rate enable from the system clock with a programmable divider, and drives colour from switches during active video.
- Adds line-start and frame-start strobes for downstream frame buffers and sprite logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, horizontal sync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, h_sync asserted level (0 = active-low)
- VS_POL, 0, v_sync asserted level
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- X_W, 10, pixel_x width (must hold H_TOTAL-1)
- Y_W, 10, pixel_y width (must hold V_TOTAL-1)
- COLOR_W, 3, colour bus width
- Localparams: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low (0 = reset)
- swcolors  in  COLOR_W  switch colour input
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- video_on_out  out  1  high in visible region
- pixel_x  out  X_W  horizontal counter
- pixel_y  out  Y_W  vertical counter
- colors_out  out  COLOR_W  colour to DAC
- clk_out  out  1  pixel tick, one clk wide
- line_start  out  1  one-clk strobe, new line
- frame_start  out  1  one-clk strobe, new frame

Behaviour:
- Reset: sampled only on rising clk edge while reset==0. Clears div_cnt, pixel_x, pixel_y, clk_out, line_start, frame_start, video_on_out and colors_out to 0. Drives h_sync=~HS_POL and v_sync=~VS_POL. Mid-frame reset takes effect on the next edge; no partial line is preserved.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. The internal tick is high when div_cnt==CLK_DIV-1. clk_out is that tick registered: high for exactly one clk every CLK_DIV clks. With CLK_DIV==1, clk_out is constantly 1 after the first post-reset edge. The first tick after reset release occurs CLK_DIV clks after release.
- Horizontal counter: on a tick, pixel_x increments. At H_TOTAL-1 it wraps to 0. Between ticks it holds.
- Vertical counter: on a tick with pixel_x==H_TOTAL-1, pixel_y increments. At V_TOTAL-1 it wraps to 0.
- line_start: high for one clk on the edge where pixel_x becomes 0 via wrap.
- frame_start: high for one clk on the edge where (pixel_x, pixel_y) become (0,0) via wrap. frame_start implies line_start in the same clk.
- Decode stage (registered, 1 clk behind the counters):
  - h_sync = HS_POL when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - v_sync = VS_POL when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - video_on_out = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
  - colors_out = swcolors when the decoded video_on is 1, else 0. swcolors is sampled in the same stage.
- Width rule: all comparisons are unsigned at X_W/Y_W. Totals that overflow X_W/Y_W are a configuration error; the block does not check for them.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: adds input test_mode (1 bit, placed after swcolors). When test_mode==1 and video is on, colors_out = pixel_x[6+COLOR_W-1:6] (vertical colour bars, 64 px wide), otherwise behaviour is unchanged.
- Undefined: the port is absent and colors_out always follows swcolors as above.

Test Plan:
- Reset and release: hold reset=0 for 3 clks. All outputs at reset values, h_sync=v_sync=1. After release, clk_out first pulses on clk 2, then every 2 clks.
- Horizontal timing (defaults): measure across a line. h_sync low for exactly 192 clks, starting 1 clk after pixel_x==656. Line period 1600 clks. line_start period 1600 clks.
- Vertical/frame (small config H=8/2/2/2, V=4/1/1/1, CLK_DIV=1): frame_start period 14*7=98 clks. v_sync low during pixel_y 5 only. video_on_out high for 8*4=32 clks per frame.
- Colour gating: swcolors=3'b101. colors_out==3'b101 only when video_on_out==1 and ==0 in porches. Change swcolors mid-line; colors_out follows 1 clk later.
- Mid-frame reset: assert reset at pixel_x=300, pixel_y=200. On the next edge, counters read 0 and syncs are inactive. After release, the first frame_start occurs after exactly one full frame.
- Polarity/divider (HS_POL=1, VS_POL=1, CLK_DIV=4): sync pulses are high-true. clk_out has period 4 clks. The VGA_TEST_PATTERN_EN build with test_mode=1 gives colors_out=3'b001 at pixel_x=64..127 on visible lines.
